// File: rtl/kbd_ascii_fifo_if.sv
// Keyboard-to-CPU character path: scancode input side and FIFO read side.
interface kbd_ascii_fifo_if #(
  parameter int DEPTH = 16
) ();
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  scancode;
  logic        code_strobe;
  logic        rd_en;
  logic        ovf_clr;
  logic [7:0]  rd_data;
  logic        empty;
  logic        full;
  logic [AW:0] count;
  logic        overflow;
  logic        shift;

  modport master (
    output scancode, code_strobe, rd_en, ovf_clr,
    input  rd_data, empty, full, count, overflow, shift
  );

  modport slave (
    input  scancode, code_strobe, rd_en, ovf_clr,
    output rd_data, empty, full, count, overflow, shift
  );
endinterface

// File: rtl/kbd_ascii_fifo.sv
// Set-2 scancode prefix tracker, ASCII decoder and first-word-fall-through
// character FIFO feeding the CPU keyboard port.
module kbd_ascii_fifo #(
  parameter int DEPTH = 16
) (
  input  logic          fclk,
  input  logic          rst,
  kbd_ascii_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  // Returns {valid, ascii} for a non-extended make code.
  function automatic logic [8:0] decode_make(input logic [7:0] code, input logic shift_held);
    logic [7:0] base;
    base = shift_held ? 8'h41 : 8'h61;
    case (code)
      8'h1C: decode_make = {1'b1, base + 8'd0};
      8'h32: decode_make = {1'b1, base + 8'd1};
      8'h21: decode_make = {1'b1, base + 8'd2};
      8'h23: decode_make = {1'b1, base + 8'd3};
      8'h24: decode_make = {1'b1, base + 8'd4};
      8'h2B: decode_make = {1'b1, base + 8'd5};
      8'h34: decode_make = {1'b1, base + 8'd6};
      8'h33: decode_make = {1'b1, base + 8'd7};
      8'h43: decode_make = {1'b1, base + 8'd8};
      8'h3B: decode_make = {1'b1, base + 8'd9};
      8'h42: decode_make = {1'b1, base + 8'd10};
      8'h4B: decode_make = {1'b1, base + 8'd11};
      8'h3A: decode_make = {1'b1, base + 8'd12};
      8'h31: decode_make = {1'b1, base + 8'd13};
      8'h44: decode_make = {1'b1, base + 8'd14};
      8'h4D: decode_make = {1'b1, base + 8'd15};
      8'h15: decode_make = {1'b1, base + 8'd16};
      8'h2D: decode_make = {1'b1, base + 8'd17};
      8'h1B: decode_make = {1'b1, base + 8'd18};
      8'h2C: decode_make = {1'b1, base + 8'd19};
      8'h3C: decode_make = {1'b1, base + 8'd20};
      8'h2A: decode_make = {1'b1, base + 8'd21};
      8'h1D: decode_make = {1'b1, base + 8'd22};
      8'h22: decode_make = {1'b1, base + 8'd23};
      8'h35: decode_make = {1'b1, base + 8'd24};
      8'h1A: decode_make = {1'b1, base + 8'd25};
      8'h45: decode_make = {1'b1, 8'h30};
      8'h16: decode_make = {1'b1, 8'h31};
      8'h1E: decode_make = {1'b1, 8'h32};
      8'h26: decode_make = {1'b1, 8'h33};
      8'h25: decode_make = {1'b1, 8'h34};
      8'h2E: decode_make = {1'b1, 8'h35};
      8'h36: decode_make = {1'b1, 8'h36};
      8'h3D: decode_make = {1'b1, 8'h37};
      8'h3E: decode_make = {1'b1, 8'h38};
      8'h46: decode_make = {1'b1, 8'h39};
      8'h29: decode_make = {1'b1, 8'h20};
      8'h5A: decode_make = {1'b1, 8'h0D};
      8'h66: decode_make = {1'b1, 8'h08};
      default: decode_make = {1'b0, 8'h00};
    endcase
  endfunction

  logic [1:0]    state_r, state_next_s;
  logic          shift_r, shift_next_s;
  logic          push_r, push_next_s;
  logic [7:0]    char_r, char_next_s;
  logic [8:0]    dec_s;
  logic          is_shift_s;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wptr_r, rptr_r, wptr_next_s, rptr_next_s;
  logic [AW:0]   count_r, count_next_s;
  logic          empty_r, full_r, overflow_r;
  logic [7:0]    rd_data_r, head_next_s;
  logic          pop_ok_s, push_eff_s, drop_s;

  // Prefix FSM, shift tracking and make decode; only strobed bytes advance it.
  always_comb begin
    state_next_s = state_r;
    shift_next_s = shift_r;
    push_next_s  = 1'b0;
    char_next_s  = 8'h00;
    dec_s        = decode_make(bus.scancode, shift_r);
    is_shift_s   = (bus.scancode == 8'h12) || (bus.scancode == 8'h59);
    if (bus.code_strobe) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.scancode == 8'hE0) begin
            state_next_s = ST_EXT;
          end else if (bus.scancode == 8'hF0) begin
            state_next_s = ST_BRK;
          end else if (is_shift_s) begin
            shift_next_s = 1'b1;
          end else begin
            push_next_s = dec_s[8];
            char_next_s = dec_s[7:0];
          end
        end
        ST_EXT: begin
          if (bus.scancode == 8'hF0) begin
            state_next_s = ST_EXT_BRK;
          end else if (bus.scancode == 8'hE0) begin
            state_next_s = ST_EXT;
          end else begin
            state_next_s = ST_IDLE;
            push_next_s  = (bus.scancode == 8'h5A);
            char_next_s  = (bus.scancode == 8'h5A) ? 8'h0D : 8'h00;
          end
        end
        ST_BRK: begin
          state_next_s = ST_IDLE;
          if (is_shift_s) begin
            shift_next_s = 1'b0;
          end else begin
            shift_next_s = shift_r;
          end
        end
        ST_EXT_BRK: state_next_s = ST_IDLE;
        default:    state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Decode pipeline register: char and push flag one edge after the strobe.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      shift_r <= 1'b0;
      push_r  <= 1'b0;
      char_r  <= 8'h00;
    end else begin
      state_r <= state_next_s;
      shift_r <= shift_next_s;
      push_r  <= push_next_s;
      char_r  <= char_next_s;
    end
  end

  // FIFO next-state; a full FIFO still accepts a push when a pop frees a slot.
  always_comb begin
    pop_ok_s     = bus.rd_en & ~empty_r;
    push_eff_s   = push_r & (~full_r | pop_ok_s);
    drop_s       = push_r & full_r & ~pop_ok_s;
    rptr_next_s  = pop_ok_s   ? rptr_r + AW'(1) : rptr_r;
    wptr_next_s  = push_eff_s ? wptr_r + AW'(1) : wptr_r;
    count_next_s = count_r + (AW+1)'(push_eff_s) - (AW+1)'(pop_ok_s);
    // The new head is the char being written when the FIFO drains to it.
    if (count_next_s == (AW+1)'(0)) begin
      head_next_s = 8'h00;
    end else if (push_eff_s && (rptr_next_s == wptr_r)) begin
      head_next_s = char_r;
    end else begin
      head_next_s = mem_r[rptr_next_s];
    end
  end

  // Character storage.
  always_ff @(posedge fclk) begin
    if (push_eff_s) begin
      mem_r[wptr_r] <= char_r;
    end
  end

  // Pointers, occupancy, flags and registered head.
  always_ff @(posedge fclk or negedge rst) begin
    if (!rst) begin
      wptr_r     <= '0;
      rptr_r     <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      rd_data_r  <= 8'h00;
    end else begin
      wptr_r     <= wptr_next_s;
      rptr_r     <= rptr_next_s;
      count_r    <= count_next_s;
      empty_r    <= (count_next_s == (AW+1)'(0));
      full_r     <= (count_next_s == (AW+1)'(DEPTH));
      overflow_r <= drop_s | (overflow_r & ~bus.ovf_clr);
      rd_data_r  <= head_next_s;
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.empty    = empty_r;
  assign bus.full     = full_r;
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
  assign bus.shift    = shift_r;
endmodule

// File: tb/tb_kbd_ascii_fifo.sv
// Scoreboard bench for kbd_ascii_fifo: a keystroke-level reference model
// predicts FIFO contents and flags; a monitor compares every cycle and on pops.
module tb_kbd_ascii_fifo;
  localparam int DEPTH = 16;

  logic fclk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  kbd_ascii_fifo_if #(.DEPTH(DEPTH)) bus ();
  kbd_ascii_fifo #(.DEPTH(DEPTH)) dut (.fclk(fclk), .rst(rst), .bus(bus));

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                    8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                    8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  // Reference model state: characters held, pending decode, prefix flags.
  logic [7:0] sb_q [$];
  bit         pend_v;
  logic [7:0] pend_c;
  bit         m_ext, m_brk, m_shift, m_ovf;
  logic [7:0] last_rd;
  bit         pop, drop;
  logic [7:0] b;
  int         r;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_make(input logic [7:0] code, input bit sh);
    for (int i = 0; i < 26; i++) if (code == letter_codes[i]) return (sh ? 65 : 97) + i;
    for (int i = 0; i < 10; i++) if (code == digit_codes[i]) return 48 + i;
    if (code == 8'h29) return 32;
    if (code == 8'h5A) return 13;
    if (code == 8'h66) return 8;
    return -1;
  endfunction

  // Model update on each edge, then compare DUT state once outputs settle.
  always @(posedge fclk) begin
    if (!rst) begin
      sb_q.delete();
      pend_v = 0; m_ext = 0; m_brk = 0; m_shift = 0; m_ovf = 0;
    end else begin
      pop  = bus.rd_en && (sb_q.size() > 0);
      drop = 0;
      if (pop) begin
        chk("pop_data", int'(last_rd), int'(sb_q[0]));
        void'(sb_q.pop_front());
      end
      if (pend_v) begin
        if (sb_q.size() < DEPTH) sb_q.push_back(pend_c);
        else drop = 1;
      end
      m_ovf  = drop || (m_ovf && !bus.ovf_clr);
      pend_v = 0;
      if (bus.code_strobe) begin
        b = bus.scancode;
        if (!m_brk && b == 8'hE0) m_ext = 1;
        else if (!m_brk && b == 8'hF0) m_brk = 1;
        else begin
          if (m_brk) begin
            if (!m_ext && (b == 8'h12 || b == 8'h59)) m_shift = 0;
          end else if (m_ext) begin
            if (b == 8'h5A) begin pend_v = 1; pend_c = 8'h0D; end
          end else if (b == 8'h12 || b == 8'h59) begin
            m_shift = 1;
          end else begin
            r = ref_make(b, m_shift);
            if (r >= 0) begin pend_v = 1; pend_c = 8'(r); end
          end
          m_ext = 0;
          m_brk = 0;
        end
      end
    end
    #1;
    chk("count", int'(bus.count), sb_q.size());
    chk("empty", int'(bus.empty), int'(sb_q.size() == 0));
    chk("full", int'(bus.full), int'(sb_q.size() == DEPTH));
    chk("overflow", int'(bus.overflow), int'(m_ovf));
    chk("shift", int'(bus.shift), int'(m_shift));
    chk("rd_data", int'(bus.rd_data), (sb_q.size() > 0) ? int'(sb_q[0]) : 0);
    last_rd = bus.rd_data;
  end

  task automatic cyc(input bit s, input logic [7:0] code, input bit rd, input bit clr);
    @(negedge fclk);
    bus.code_strobe = s;
    bus.scancode    = code;
    bus.rd_en       = rd;
    bus.ovf_clr     = clr;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic drain();
    repeat (DEPTH + 2) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
  endtask

  task automatic send(input logic [7:0] code);
    cyc(1'b1, code, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    bus.code_strobe = 1'b0; bus.scancode = 8'h00; bus.rd_en = 1'b0; bus.ovf_clr = 1'b0;
    idle(2);
    chk("reset_empty", int'(bus.empty), 1);
    chk("reset_rd_data", int'(bus.rd_data), 0);
    rst = 1'b1;
    idle(1);

    // Single make, two-edge latency, then pop.
    send(8'h1C); idle(2);
    chk("a_rd_data", int'(bus.rd_data), 8'h61);
    chk("a_count", int'(bus.count), 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0); idle(1);
    chk("a_popped_empty", int'(bus.empty), 1);

    // Shifted letter, break codes, unshifted letter.
    send(8'h12); idle(2);
    chk("shift_set", int'(bus.shift), 1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12); idle(1);
    chk("shift_cleared", int'(bus.shift), 0);
    send(8'h1C); idle(2);
    chk("shift_seq_count", int'(bus.count), 2);
    chk("shift_seq_head", int'(bus.rd_data), 8'h41);
    drain();

    // Extended sequences: only E0 5A pushes.
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
    send(8'hE0); send(8'h75); send(8'h0E); idle(2);
    chk("ext_count", int'(bus.count), 1);
    chk("ext_head", int'(bus.rd_data), 8'h0D);
    drain();

    // Overflow: DEPTH+2 digits back to back.
    for (int i = 0; i < DEPTH + 2; i++) send(digit_codes[i % 10]);
    idle(2);
    chk("ovf_count", int'(bus.count), DEPTH);
    chk("ovf_flag", int'(bus.overflow), 1);
    chk("ovf_head", int'(bus.rd_data), 8'h30);
    drain();
    cyc(1'b0, 8'h00, 1'b0, 1'b1); idle(1);
    chk("ovf_cleared", int'(bus.overflow), 0);

    // Full FIFO: pop coinciding with an arriving write.
    for (int i = 0; i < DEPTH; i++) send(letter_codes[i]);
    idle(2);
    send(8'h29);
    cyc(1'b0, 8'h00, 1'b1, 1'b0); idle(1);
    chk("fullrw_count", int'(bus.count), DEPTH);
    chk("fullrw_ovf", int'(bus.overflow), 0);
    chk("fullrw_head", int'(bus.rd_data), 8'h62);
    drain();

    // Reset between F0 and 12 while shifted.
    send(8'h1C); send(8'h12); send(8'hF0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("rst_shift", int'(bus.shift), 0);
    chk("rst_count", int'(bus.count), 0);
    idle(2);
    rst = 1'b1;
    idle(1);
    send(8'h12); idle(2);
    chk("rst_then_make_shift", int'(bus.shift), 1);
    send(8'hF0); send(8'h12); idle(1);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] code;
      case ($urandom_range(0, 9))
        0:       code = 8'hE0;
        1:       code = 8'hF0;
        2:       code = ($urandom_range(0, 1) == 0) ? 8'h12 : 8'h59;
        3, 4:    code = letter_codes[$urandom_range(0, 25)];
        5:       code = digit_codes[$urandom_range(0, 9)];
        6:       code = ($urandom_range(0, 1) == 0) ? 8'h29 : 8'h5A;
        7:       code = 8'h66;
        default: code = 8'($urandom_range(0, 255));
      endcase
      cyc($urandom_range(0, 9) < 6, code, $urandom_range(0, 9) < 3,
          $urandom_range(0, 19) == 0);
    end
    idle(2);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
